// File: rtl/frame_checker.sv
// Stream checker for the counter-pattern frame generator: pass-through,
// tlast insertion, per-beat pattern check and error/frame statistics.
module frame_checker #(
   parameter int DW = 512
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   frame_size,
   input  logic          clear,
   input  logic [DW-1:0] axis_in_tdata,
   input  logic          axis_in_tvalid,
   output logic          axis_in_tready,
   output logic [DW-1:0] axis_out_tdata,
   output logic          axis_out_tvalid,
   output logic          axis_out_tlast,
   input  logic          axis_out_tready,
   output logic [31:0]   frame_count,
   output logic [31:0]   error_count,
   output logic          err_latched,
   output logic [31:0]   first_err_frame,
   output logic [31:0]   first_err_beat
);

   localparam int LANES = DW / 16;
   localparam int SH    = $clog2(DW / 8);

   logic [31:0] beat_q, beat_d;
   logic [31:0] fidx_q, fidx_d;
   logic [31:0] fcnt_q, fcnt_d;
   logic [31:0] ecnt_q, ecnt_d;
   logic [31:0] ffr_q, ffr_d;
   logic [31:0] fbt_q, fbt_d;
   logic [31:0] bpf_q, bpf_d;
   logic [15:0] exp_q, exp_d;
   logic        lat_q, lat_d;

   logic [31:0] bpf_live;
   logic [31:0] bpf_act;
   logic        accept;
   logic        last;
   logic        bad;

   assign axis_out_tdata  = axis_in_tdata;
   assign axis_out_tvalid = axis_in_tvalid;
   assign axis_in_tready  = axis_out_tready;
   assign accept          = axis_in_tvalid & axis_out_tready;

   always_comb begin
      bpf_live = frame_size >> SH;
      if (bpf_live == 32'd0) bpf_live = 32'd1;
   end

   // Frame length is frozen at beat 0; later frame_size changes wait a frame.
   assign bpf_act = (beat_q == 32'd0) ? bpf_live : bpf_q;
   assign last    = (beat_q == bpf_act - 32'd1);

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (axis_in_tdata[i*16 +: 16] != exp_q) bad = 1'b1;
      end
   end

   always_comb begin
      beat_d = beat_q;
      fidx_d = fidx_q;
      fcnt_d = fcnt_q;
      ecnt_d = ecnt_q;
      ffr_d  = ffr_q;
      fbt_d  = fbt_q;
      bpf_d  = bpf_q;
      exp_d  = exp_q;
      lat_d  = lat_q;
      if (clear) begin
         beat_d = '0;
         fidx_d = '0;
         fcnt_d = '0;
         ecnt_d = '0;
         ffr_d  = '0;
         fbt_d  = '0;
         exp_d  = '0;
         lat_d  = 1'b0;
      end else if (accept) begin
         if (beat_q == 32'd0) bpf_d = bpf_live;
         if (last) begin
            beat_d = '0;
            fidx_d = fidx_q + 32'd1;
            if (fcnt_q != '1) fcnt_d = fcnt_q + 32'd1;
         end else begin
            beat_d = beat_q + 32'd1;
         end
         exp_d = exp_q + 16'd1;
         if (bad) begin
            if (ecnt_q != '1) ecnt_d = ecnt_q + 32'd1;
            if (!lat_q) begin
               lat_d = 1'b1;
               ffr_d = fidx_q;
               fbt_d = beat_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q <= '0;
         fidx_q <= '0;
         fcnt_q <= '0;
         ecnt_q <= '0;
         ffr_q  <= '0;
         fbt_q  <= '0;
         bpf_q  <= 32'd1;
         exp_q  <= '0;
         lat_q  <= 1'b0;
      end else begin
         beat_q <= beat_d;
         fidx_q <= fidx_d;
         fcnt_q <= fcnt_d;
         ecnt_q <= ecnt_d;
         ffr_q  <= ffr_d;
         fbt_q  <= fbt_d;
         bpf_q  <= bpf_d;
         exp_q  <= exp_d;
         lat_q  <= lat_d;
      end
   end

   assign axis_out_tlast  = last;
   assign frame_count     = fcnt_q;
   assign error_count     = ecnt_q;
   assign err_latched     = lat_q;
   assign first_err_frame = ffr_q;
   assign first_err_beat  = fbt_q;

endmodule

// File: tb/tb_frame_checker.sv
// Scoreboard bench for frame_checker: directed streams, throttling,
// frame-size changes, pattern wrap, clear and reset recovery.
module tb_frame_checker;

   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   frame_size;
   logic          clear;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready;
   logic [31:0]   frame_count;
   logic [31:0]   error_count;
   logic          err_latched;
   logic [31:0]   first_err_frame;
   logic [31:0]   first_err_beat;

   int n_chk  = 0;
   int n_fail = 0;
   int n_mon  = 0;
   logic [DW:0] sb[$];

   frame_checker #(.DW(DW)) dut (
      .clk             (clk),
      .reset           (reset),
      .frame_size      (frame_size),
      .clear           (clear),
      .axis_in_tdata   (in_data),
      .axis_in_tvalid  (in_valid),
      .axis_in_tready  (in_ready),
      .axis_out_tdata  (out_data),
      .axis_out_tvalid (out_valid),
      .axis_out_tlast  (out_last),
      .axis_out_tready (out_ready),
      .frame_count     (frame_count),
      .error_count     (error_count),
      .err_latched     (err_latched),
      .first_err_frame (first_err_frame),
      .first_err_beat  (first_err_beat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rep(input logic [15:0] v);
      return {(DW/16){v}};
   endfunction

   // Monitor: pops one expectation per output handshake.
   always @(negedge clk) begin
      logic [DW:0] e;
      if (!reset && out_valid && out_ready) begin
         n_mon++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_extra: unexpected beat, got %0h", out_data[31:0]);
         end else begin
            e = sb.pop_front();
            n_chk++;
            if (out_data !== e[DW-1:0]) begin
               n_fail++;
               $display("FAIL tdata: got %h expected %h", out_data, e[DW-1:0]);
            end
            chk("tlast", 32'(out_last), 32'(e[DW]));
            chk("tready_pass", 32'(in_ready), 32'd1);
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic tl,
                       input logic clr, input bit thr);
      int guard;
      if (thr) begin
         repeat ($urandom_range(0, 2)) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
      end
      sb.push_back({tl, d});
      in_data  = d;
      in_valid = 1'b1;
      clear    = clr;
      guard    = 0;
      do begin
         out_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         guard++;
      end while (!out_ready && guard < 1000);
      if (guard >= 1000) chk("handshake_timeout", 32'd1, 32'd0);
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic status(input string t, input logic [31:0] fc,
                         input logic [31:0] ec, input logic lt,
                         input logic [31:0] ff, input logic [31:0] fb);
      chk({t, "_frame_count"}, frame_count, fc);
      chk({t, "_error_count"}, error_count, ec);
      chk({t, "_err_latched"}, 32'(err_latched), 32'(lt));
      chk({t, "_first_err_frame"}, first_err_frame, ff);
      chk({t, "_first_err_beat"}, first_err_beat, fb);
      chk({t, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] d;
      int m0;
      reset      = 1'b1;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      frame_size = 32'd1024;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      status("reset", 0, 0, 0, 0, 0);
      chk("reset_tlast", 32'(out_last), 32'd0);

      // Three clean 16-beat frames
      for (int i = 0; i < 48; i++)
         send(rep(16'(i)), (i % 16) == 15, 1'b0, 1'b0);
      status("clean", 3, 0, 0, 0, 0);

      // Same stream, lane 5 of beat 20 corrupted
      do_reset();
      for (int i = 0; i < 48; i++) begin
         d = rep(16'(i));
         if (i == 20) d[5*16 +: 16] = 16'hDEAD;
         send(d, (i % 16) == 15, 1'b0, 1'b0);
      end
      status("corrupt", 3, 1, 1, 1, 4);

      // Throttled two-frame run
      do_reset();
      m0 = n_mon;
      for (int i = 0; i < 32; i++)
         send(rep(16'(i)), (i % 16) == 15, 1'b0, 1'b1);
      chk("thr_beats", 32'(n_mon - m0), 32'd32);
      status("thr", 2, 0, 0, 0, 0);

      // Sub-beat frame size: every beat is last
      do_reset();
      frame_size = 32'd32;
      for (int i = 0; i < 5; i++)
         send(rep(16'(i)), 1'b1, 1'b0, 1'b0);
      status("tiny", 5, 0, 0, 0, 0);

      // Frame size change mid-frame applies next frame
      do_reset();
      frame_size = 32'd1024;
      for (int i = 0; i < 48; i++) begin
         if (i == 8) frame_size = 32'd2048;
         send(rep(16'(i)), (i == 15) || (i == 47), 1'b0, 1'b0);
      end
      status("resize", 2, 0, 0, 0, 0);

      // Pattern wrap past 0xFFFF
      do_reset();
      frame_size = 32'd1024;
      for (int i = 0; i < 65540; i++)
         send(rep(16'(i)), (i % 16) == 15, 1'b0, 1'b0);
      status("wrap", 4096, 0, 0, 0, 0);

      // Clear on an accepted mid-frame beat
      do_reset();
      for (int i = 0; i < 6; i++)
         send(rep(16'(i)), 1'b0, 1'b0, 1'b0);
      send(rep(16'hBAD0), 1'b0, 1'b1, 1'b0);
      status("clear", 0, 0, 0, 0, 0);
      send(rep(16'd0), 1'b0, 1'b0, 1'b0);
      status("clear_d0", 0, 0, 0, 0, 0);
      send(rep(16'd5), 1'b0, 1'b1, 1'b0);
      send(rep(16'd1), 1'b0, 1'b0, 1'b0);
      status("clear_d1", 0, 1, 1, 0, 0);

      // Reset mid-frame
      for (int i = 0; i < 5; i++)
         send(rep(16'(i + 2)), 1'b0, 1'b0, 1'b0);
      do_reset();
      status("rst", 0, 0, 0, 0, 0);
      send(rep(16'd0), 1'b0, 1'b0, 1'b0);
      status("rst_d0", 0, 0, 0, 0, 0);
      do_reset();
      send(rep(16'd1), 1'b0, 1'b0, 1'b0);
      status("rst_d1", 0, 1, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
